// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared types and defaults for the MIYAJIRO_CPU run
//                controller. Holds the sequencer state encoding, the default
//                reset/run lengths and a small counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Run sequencer states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RESET_HOLD = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } run_state_t;

    localparam int DEF_RESET_CYCLES = 2;
    localparam int DEF_MAX_CYCLES   = 100;

    // Width needed for a counter that must represent 0..max_val (min 1 bit).
    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_controller
//  Description : Run sequencer for MIYAJIRO_CPU. Holds the core in reset for
//                RESET_CYCLES clocks, then runs it for up to MAX_CYCLES
//                enabled clocks (0 = unbounded), stopping early on halt.
//                Supports pause, restart from DONE and status reporting.
//  Ports       : clk          - system clock, rising edge
//                reset_n      - asynchronous active-low reset
//                start        - pulse, begin/restart a run (IDLE/DONE only)
//                pause        - level, freezes CPU clock enable in RUN
//                halt_in      - CPU halt indication, sampled in RUN
//                cpu_reset_n  - registered active-low reset to the CPU
//                cpu_clk_en   - CPU clock enable (combinational)
//                running      - high while in RUN
//                done         - registered, high in DONE
//                timed_out    - registered, high in DONE after a timeout
//                cycle_count  - enabled run cycles of current/last run
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int CNT_W        = 32,
    parameter int AUTO_START   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    input  logic             halt_in,
    output logic             cpu_reset_n,
    output logic             cpu_clk_en,
    output logic             running,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int               HOLD_W       = count_width(RESET_CYCLES);
    // The hold counter counts 0..RESET_CYCLES-1; the edge taken while it
    // shows the last value is the one that moves the sequencer into RUN.
    localparam logic [HOLD_W-1:0] C_HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_MAX_COUNT  = CNT_W'(MAX_CYCLES);
    localparam bit                C_TIMEOUT_EN = (MAX_CYCLES != 0);
    localparam bit                C_AUTO_START = (AUTO_START != 0);

    run_state_t        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0]  r_count;
    logic              r_cpu_reset_n;
    logic              r_done;
    logic              r_timed_out;

    run_state_t        w_state_next;
    logic [HOLD_W-1:0] w_hold_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [CNT_W-1:0]  w_count_inc;
    logic              w_timed_out_next;
    logic              w_clk_en;

    // ------------------------------------------------------------------
    // Next-state and next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_hold_next      = '0;
        w_count_next     = r_count;
        w_timed_out_next = r_timed_out;
        w_clk_en         = (r_state == ST_RUN) && !pause;
        // Saturating increment; only reachable when no timeout is configured.
        w_count_inc      = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (C_AUTO_START || start) begin
                    w_state_next = ST_RESET_HOLD;
                end
            end

            ST_RESET_HOLD: begin
                if (r_hold_cnt == C_HOLD_LAST) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_hold_next = r_hold_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                if (w_clk_en) begin
                    w_count_next = w_count_inc;
                end
                // Halt is checked first so that a halt coinciding with the
                // final counted cycle is reported as a halt, not a timeout.
                // Pause gates only the count, never the halt.
                if (halt_in) begin
                    w_state_next     = ST_DONE;
                    w_timed_out_next = 1'b0;
                end else if (C_TIMEOUT_EN && w_clk_en && (w_count_inc == C_MAX_COUNT)) begin
                    w_state_next     = ST_DONE;
                    w_timed_out_next = 1'b1;
                end
            end

            ST_DONE: begin
                if (start) begin
                    w_state_next     = ST_RESET_HOLD;
                    w_count_next     = '0;
                    w_timed_out_next = 1'b0;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_count       <= '0;
            r_cpu_reset_n <= 1'b0;
            r_done        <= 1'b0;
            r_timed_out   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_hold_cnt    <= w_hold_next;
            r_count       <= w_count_next;
            // CPU reset is released on the edge entering RUN and stays
            // released in DONE so the core can be inspected after a run.
            r_cpu_reset_n <= (w_state_next == ST_RUN) || (w_state_next == ST_DONE);
            r_done        <= (w_state_next == ST_DONE);
            r_timed_out   <= w_timed_out_next;
        end
    end

    assign cpu_reset_n = r_cpu_reset_n;
    assign cpu_clk_en  = w_clk_en;
    assign running     = (r_state == ST_RUN);
    assign done        = r_done;
    assign timed_out   = r_timed_out;
    assign cycle_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_run_controller
//  Description : Self-checking bench for cpu_run_controller. Instance A uses
//                the default parameters; instance B uses AUTO_START=0, no
//                timeout and a 4-bit counter to reach saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_controller;
    import cpu_ctrl_pkg::*;

    localparam int RC   = DEF_RESET_CYCLES;
    localparam int MAXC = DEF_MAX_CYCLES;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (defaults)
    logic        reset_n = 1'b1;
    logic        start = 1'b0, pause = 1'b0, halt_in = 1'b0;
    logic        cpu_reset_n, cpu_clk_en, running, done, timed_out;
    logic [31:0] cycle_count;

    // Instance B (manual start, no timeout, 4-bit count)
    logic        reset_n_b = 1'b1;
    logic        start_b = 1'b0, pause_b = 1'b0, halt_b = 1'b0;
    logic        cpu_reset_n_b, cpu_clk_en_b, running_b, done_b, timed_out_b;
    logic [3:0]  cycle_count_b;

    cpu_run_controller #(
        .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .CNT_W(32), .AUTO_START(1)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause),
        .halt_in(halt_in), .cpu_reset_n(cpu_reset_n), .cpu_clk_en(cpu_clk_en),
        .running(running), .done(done), .timed_out(timed_out),
        .cycle_count(cycle_count)
    );

    cpu_run_controller #(
        .RESET_CYCLES(3), .MAX_CYCLES(0), .CNT_W(4), .AUTO_START(0)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n_b), .start(start_b), .pause(pause_b),
        .halt_in(halt_b), .cpu_reset_n(cpu_reset_n_b), .cpu_clk_en(cpu_clk_en_b),
        .running(running_b), .done(done_b), .timed_out(timed_out_b),
        .cycle_count(cycle_count_b)
    );

    typedef struct packed {
        logic        rstn;
        logic        en;
        logic        run;
        logic        dn;
        logic        to;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic s;
        logic p;
        logic h;
        exp_t e;
    } vec_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model of instance A (phase 0 idle, 1 hold, 2 run, 3 done)
    int          m_phase;
    int          m_hold;
    logic [31:0] m_cnt;
    logic        m_rstn, m_done, m_to;

    task automatic model_reset();
        m_phase = 0; m_hold = 0; m_cnt = 0;
        m_rstn = 1'b0; m_done = 1'b0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic h);
        case (m_phase)
            0: begin
                m_phase = 1;  // auto-start leaves idle unconditionally
                m_hold  = 0;
            end
            1: begin
                m_hold = m_hold + 1;
                if (m_hold == RC) begin
                    m_phase = 2;
                    m_rstn  = 1'b1;
                end
            end
            2: begin
                if (!p && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (h) begin
                    m_phase = 3; m_done = 1'b1; m_to = 1'b0;
                end else if (!p && m_cnt == MAXC) begin
                    m_phase = 3; m_done = 1'b1; m_to = 1'b1;
                end
            end
            default: begin
                if (s) begin
                    m_phase = 1; m_hold = 0; m_cnt = 0;
                    m_done = 1'b0; m_to = 1'b0; m_rstn = 1'b0;
                end
            end
        endcase
    endtask

    function automatic exp_t model_exp(input logic p);
        exp_t e;
        e.rstn = m_rstn;
        e.en   = (m_phase == 2) && !p;
        e.run  = (m_phase == 2);
        e.dn   = m_done;
        e.to   = m_to;
        e.cnt  = m_cnt;
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, req, $time);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty (t=%0t)", tag, $time);
        end else begin
            e = sb_q.pop_front();
            if ({cpu_reset_n, cpu_clk_en, running, done, timed_out, cycle_count} === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got rstn=%b en=%b run=%b done=%b to=%b cnt=%0d, expected rstn=%b en=%b run=%b done=%b to=%b cnt=%0d (t=%0t)",
                         tag, cpu_reset_n, cpu_clk_en, running, done, timed_out, cycle_count,
                         e.rstn, e.en, e.run, e.dn, e.to, e.cnt, $time);
            end
        end
    endtask

    // One clock of instance A: drive at negedge, queue the expectation,
    // compare 1 time unit after the rising edge.
    task automatic drive_cycle(input logic s, input logic p, input logic h,
                               input logic use_tbl, input exp_t tbl_e, input string tag);
        @(negedge clk);
        start = s; pause = p; halt_in = h;
        model_step(s, p, h);
        if (use_tbl) sb_q.push_back(tbl_e);
        else         sb_q.push_back(model_exp(p));
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    task automatic cyc(input logic s, input logic p, input logic h, input string tag);
        drive_cycle(s, p, h, 1'b0, '0, tag);
    endtask

    task automatic run_to_count(input logic [31:0] target, input string tag);
        for (int i = 0; i < 300 && m_cnt != target; i++) cyc(1'b0, 1'b0, 1'b0, tag);
        check_val({tag, "_reached"}, cycle_count, target);
    endtask

    task automatic tick_b(input logic s, input logic h);
        @(negedge clk);
        start_b = s; halt_b = h;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        // Startup vectors after reset release: two hold cycles, RUN entry,
        // first enabled edge, start ignored in RUN, pause freezing the count.
        vecs[0] = '{s:1'b0, p:1'b0, h:1'b0, e:'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}};
        vecs[1] = '{s:1'b0, p:1'b0, h:1'b0, e:'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}};
        vecs[2] = '{s:1'b0, p:1'b0, h:1'b0, e:'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0}};
        vecs[3] = '{s:1'b0, p:1'b0, h:1'b0, e:'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1}};
        vecs[4] = '{s:1'b1, p:1'b0, h:1'b0, e:'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2}};
        vecs[5] = '{s:1'b0, p:1'b1, h:1'b0, e:'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2}};
        vecs[6] = '{s:1'b0, p:1'b1, h:1'b0, e:'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2}};
        vecs[7] = '{s:1'b0, p:1'b0, h:1'b0, e:'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3}};

        // ---------------- reset ----------------
        #1;
        reset_n = 1'b0; reset_n_b = 1'b0;
        #1;
        check_val("async_reset_rstn", cpu_reset_n, 0);
        check_val("async_reset_done", done, 0);
        check_val("async_reset_cnt", cycle_count, 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_hold_rstn", cpu_reset_n, 0);
        check_val("reset_hold_run", running, 0);
        check_val("reset_hold_en", cpu_clk_en, 0);
        check_val("reset_hold_to", timed_out, 0);
        #1;
        reset_n = 1'b1; reset_n_b = 1'b1;
        model_reset();

        // ---------------- table: startup ----------------
        for (int i = 0; i < 8; i++) begin
            drive_cycle(vecs[i].s, vecs[i].p, vecs[i].h, 1'b1, vecs[i].e, $sformatf("vec%0d", i));
        end

        // ---------------- pause at 20 for 10 cycles, then timeout ----------------
        run_to_count(32'd20, "run_to_20");
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, "pause");
        check_val("pause_cnt", cycle_count, 20);
        check_val("pause_en", cpu_clk_en, 0);
        for (int i = 0; i < 200 && !m_done; i++) cyc(1'b0, 1'b0, 1'b0, "to_timeout");
        check_val("timeout_done", done, 1);
        check_val("timeout_flag", timed_out, 1);
        check_val("timeout_cnt", cycle_count, 100);
        check_val("timeout_en", cpu_clk_en, 0);
        check_val("timeout_rstn", cpu_reset_n, 1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, "done_hold");
        check_val("done_hold_cnt", cycle_count, 100);

        // ---------------- restart, halt at 37 ----------------
        cyc(1'b1, 1'b0, 1'b0, "restart1");
        check_val("restart_rstn", cpu_reset_n, 0);
        check_val("restart_cnt", cycle_count, 0);
        check_val("restart_done", done, 0);
        check_val("restart_to", timed_out, 0);
        for (int i = 0; i < RC; i++) cyc(1'b0, 1'b0, 1'b0, "rehold");
        check_val("rehold_rstn", cpu_reset_n, 1);
        run_to_count(32'd37, "run_to_37");
        cyc(1'b0, 1'b0, 1'b1, "halt37");
        check_val("halt37_done", done, 1);
        check_val("halt37_to", timed_out, 0);
        check_val("halt37_cnt", cycle_count, 38);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, "after_halt");
        check_val("after_halt_cnt", cycle_count, 38);

        // ---------------- restart, halt on final cycle ----------------
        cyc(1'b1, 1'b0, 1'b0, "restart2");
        run_to_count(32'd99, "run_to_99");
        cyc(1'b0, 1'b0, 1'b1, "halt_final");
        check_val("halt_final_done", done, 1);
        check_val("halt_final_to", timed_out, 0);
        check_val("halt_final_cnt", cycle_count, 100);

        // ---------------- restart, async reset at 50 ----------------
        cyc(1'b1, 1'b0, 1'b0, "restart3");
        run_to_count(32'd50, "run_to_50");
        #2;
        reset_n = 1'b0;
        #1;
        check_val("midreset_rstn", cpu_reset_n, 0);
        check_val("midreset_en", cpu_clk_en, 0);
        check_val("midreset_run", running, 0);
        check_val("midreset_done", done, 0);
        check_val("midreset_to", timed_out, 0);
        check_val("midreset_cnt", cycle_count, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < RC + 2; i++) cyc(1'b0, 1'b0, 1'b0, "post_reset");
        check_val("post_reset_cnt", cycle_count, 1);

        // ---------------- instance B: manual start ----------------
        tick_b(1'b0, 1'b1);  // halt ignored while idle
        check_val("b_idle_rstn", cpu_reset_n_b, 0);
        check_val("b_idle_run", running_b, 0);
        check_val("b_idle_done", done_b, 0);
        check_val("b_idle_cnt", cycle_count_b, 0);
        tick_b(1'b1, 1'b0);
        check_val("b_hold1_rstn", cpu_reset_n_b, 0);
        tick_b(1'b0, 1'b0);
        tick_b(1'b0, 1'b0);
        check_val("b_hold3_rstn", cpu_reset_n_b, 0);
        tick_b(1'b0, 1'b0);
        check_val("b_run_rstn", cpu_reset_n_b, 1);
        check_val("b_run_running", running_b, 1);
        check_val("b_run_cnt", cycle_count_b, 0);
        for (int i = 0; i < 20; i++) tick_b(1'b0, 1'b0);
        check_val("b_sat_cnt", cycle_count_b, 15);
        check_val("b_sat_running", running_b, 1);
        check_val("b_sat_done", done_b, 0);
        tick_b(1'b0, 1'b1);
        check_val("b_halt_done", done_b, 1);
        check_val("b_halt_to", timed_out_b, 0);
        check_val("b_halt_cnt", cycle_count_b, 15);
        check_val("b_halt_en", cpu_clk_en_b, 0);
        tick_b(1'b0, 1'b0);

        check_val("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Synthesisable run controller for MIYAJIRO_CPU. It replaces hard-coded reset and run timing with a parametrised sequencer: hold the core in reset for N cycles, run it for a bounded number of enabled cycles, and stop early on halt. It supports pause, restart and status/cycle reporting. It sits between the board or bench clock/reset and the CPU's reset_n and clock enable, and is reused by the testbench and the FPGA top.

Parameters:
RESET_CYCLES, 2, cycles cpu_reset_n is held low after entering RESET_HOLD (≥1)
MAX_CYCLES, 100, enabled run cycles before timeout; 0 = no timeout
CNT_W, 32, width of cycle_count (must hold MAX_CYCLES)
AUTO_START, 1, 1 = leave IDLE automatically on first clock after reset release

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse: begin or restart a run (IDLE/DONE only)
pause  input  1  level: freezes CPU clock enable and counter while RUN
halt_in  input  1  CPU halt indication, sampled each cycle in RUN
cpu_reset_n  output  1  registered reset to CPU, active-low
cpu_clk_en  output  1  CPU clock enable
running  output  1  high in RUN
done  output  1  registered; high in DONE
timed_out  output  1  registered; high in DONE if the run ended by MAX_CYCLES
cycle_count  output  CNT_W  enabled run cycles of current/last run

Behaviour:
- reset_n low, asynchronous: state=IDLE, cpu_reset_n=0, done=0, timed_out=0, cycle_count=0, hold counter=0. Combinational outputs cpu_clk_en=0, running=0.
- States: IDLE, RESET_HOLD, RUN, DONE.
- IDLE: cpu_reset_n=0.
  - Goes to RESET_HOLD when AUTO_START=1 (first edge after release) or start=1.
  - With AUTO_START=1, start is don't-care.
- RESET_HOLD: cpu_reset_n=0, hold counter increments each cycle.
  - After exactly RESET_CYCLES cycles in the state, go to RUN.
  - cpu_reset_n rises on that same edge.
  - Deassertion is synchronous to clk; assertion follows reset_n asynchronously.
- RUN: running=1; cpu_clk_en = !pause (combinational).
  - cycle_count += 1 on each edge where cpu_clk_en=1.
  - Saturates at all-ones.
- RUN exit on halt: halt_in=1 on an edge → DONE, done=1, timed_out=0. Pause does not mask halt.
- RUN exit on timeout: MAX_CYCLES≠0 and the increment makes cycle_count==MAX_CYCLES → DONE, done=1, timed_out=1.
- Simultaneous halt and final cycle: halt wins, timed_out=0, and the count still increments to MAX_CYCLES.
- DONE: cpu_reset_n stays 1 (CPU state preserved for inspection), cpu_clk_en=0, cycle_count held.
  - start=1 → RESET_HOLD, clearing cycle_count, done, timed_out and the hold counter on that edge.
  - cpu_reset_n drops to 0 on the same edge.
- start in RESET_HOLD or RUN is ignored.
- halt_in outside RUN is ignored.
- reset_n asserted mid-operation: immediate return to reset values. The CPU is reset asynchronously via cpu_reset_n.
- Latency:
  - From reset_n release with AUTO_START=1, the first CPU-enabled edge is edge 1+RESET_CYCLES+1.
  - Halt to done is 1 edge.

Decomposition:
- Shared package cpu_ctrl_pkg: state typedef (IDLE, RESET_HOLD, RUN, DONE, 2-bit encoding) and default constants DEF_RESET_CYCLES=2, DEF_MAX_CYCLES=100.
- No sub-module; single FSM plus two counters.
- The testbench instantiates this block and ends simulation on done.

Test Plan:
- Defaults, reset_n low 2 edges then high, no halt → cpu_reset_n=0 for 2 cycles after IDLE, then 1. After 100 enabled edges: done=1, timed_out=1, cycle_count=100, cpu_clk_en=0.
- halt_in pulsed when cycle_count=37 → next edge done=1, timed_out=0, cycle_count=38. Further clocks leave cycle_count at 38.
- pause high for 10 cycles mid-run at count=20 → cpu_clk_en=0 and count stays 20. After release, timeout still at exactly 100 enabled edges.
- halt_in asserted on the edge where count goes 99→100 → done=1, timed_out=0, cycle_count=100.
- In DONE, start pulse → cpu_reset_n=0, count=0, done=0 on that edge. RESET_CYCLES later cpu_reset_n=1 and the run resumes. start during RUN → no effect.
- AUTO_START=0: no state change until start. Also reset_n pulsed low at count=50 → all outputs return to reset values immediately (asynchronously), before the next clock edge.
